// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern source and its detector bench.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DIV   = 1;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: tick is high on the last of DIV cycles of each bit.
module bit_tick_gen
  import seq_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick is precomputed from the next count so it can be a flop output
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
    end
    tick_d = (clear | enable) & (cnt_d == CW'(DIV - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial pattern source: MSB-first, each bit held DIV cycles,
// idle-low line, one-cycle done pulse after the last bit.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV   = DEF_DIV,
  parameter int unsigned LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LW-1:0]    len,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LW-1:0]    bits_left_q, bits_left_d;
  logic             serial_q, serial_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             tick;
  logic [LW-1:0]    align;

  assign accept = (state_q == IDLE) && start && (len != '0) && (len <= LW'(WIDTH));
  assign align  = LW'(WIDTH) - len;

  bit_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .enable(busy_q),
    .tick  (tick)
  );

  // Outputs are computed one cycle ahead so every port is a flop
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    serial_d    = serial_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d     = data << align;
          bits_left_d = len;
          serial_d    = shreg_d[WIDTH-1];
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          shreg_d     = shreg_q << 1;
          bits_left_d = bits_left_q - LW'(1);
          if (bits_left_q == LW'(1)) begin
            serial_d = 1'b0;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            serial_d = shreg_d[WIDTH-1];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      serial_q    <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      serial_q    <= serial_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign serial_out = serial_q;
  assign bit_valid  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
